// File: rtl/eth_xmii_tx.sv
// eth_xmii_tx: Ethernet MAC transmit serializer for RMII (DW=2) and MII (DW=4) PHYs.
// The ETH_XMII_TX_FCS_EN macro enables the built-in CRC-32 and appends the 4-byte FCS to each frame.
`timescale 1ns/1ps
module eth_xmii_tx #(
    parameter int DW        = 2,
    parameter int PRE_BYTES = 7,
    parameter int MIN_BYTES = 60,
    parameter int IPG_BYTES = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    data,
    input  logic          packet,
    output logic [DW-1:0] tx,
    output logic          txen,
    output logic          advance,
    output logic          busy,
    output logic [10:0]   len
);
    localparam int S    = 8 / DW;
    localparam int SW   = $clog2(S);
    localparam int BMAX = (PRE_BYTES > IPG_BYTES) ? ((PRE_BYTES > 4) ? PRE_BYTES : 4)
                                                  : ((IPG_BYTES > 4) ? IPG_BYTES : 4);
    localparam int BW   = $clog2(BMAX);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
`ifdef ETH_XMII_TX_FCS_EN
        FCS,
`endif
        IPG
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   sym_reg, sym_next, sym_inc;
    logic [BW-1:0]   bcnt_reg, bcnt_next;
    logic [7:0]      byte_reg, byte_next;
    logic [7:0]      nxt_reg, nxt_next;
    logic            have_reg, have_next;
    logic [DW-1:0]   tx_next;
    logic            txen_next, adv_next, busy_next;
    logic [10:0]     len_next, len_inc;
    logic            last_sym, bound_sym, pad_more;
    logic            end_frame, enter_ipg;
    logic [DW-1:0]   byte_sym [S];

`ifdef ETH_XMII_TX_FCS_EN
    logic [31:0]     crc_reg, crc_base, crc_next;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DW-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < DW; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    assign last_sym  = (sym_reg == SW'(S - 1));
    assign bound_sym = (sym_reg == SW'(S - 2));
    assign sym_inc   = last_sym ? '0 : sym_reg + SW'(1);
    assign len_inc   = (len == 11'h7FF) ? len : len + 11'd1;
    assign pad_more  = (len < 11'(MIN_BYTES));

    always_comb begin
        state_next = state_reg;
        sym_next   = sym_reg;
        bcnt_next  = bcnt_reg;
        byte_next  = byte_reg;
        nxt_next   = nxt_reg;
        have_next  = have_reg;
        txen_next  = txen;
        busy_next  = busy;
        adv_next   = 1'b0;
        len_next   = len;
        end_frame  = 1'b0;
        enter_ipg  = 1'b0;
`ifdef ETH_XMII_TX_FCS_EN
        crc_base   = crc_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                txen_next = 1'b0;
                busy_next = 1'b0;
                byte_next = '0;
                sym_next  = '0;
                if (packet) begin
                    state_next = PRE;
                    bcnt_next  = BW'(PRE_BYTES - 1);
                    byte_next  = 8'h55;
                    txen_next  = 1'b1;
                    busy_next  = 1'b1;
                    len_next   = '0;
                    have_next  = 1'b0;
`ifdef ETH_XMII_TX_FCS_EN
                    crc_base   = '1;
`endif
                end
            end
            PRE: begin
                sym_next = sym_inc;
                if (last_sym) begin
                    if (bcnt_reg == '0) begin
                        state_next = SFD;
                        byte_next  = 8'hD5;
                    end else begin
                        bcnt_next = bcnt_reg - BW'(1);
                    end
                end
            end
            SFD, DATA: begin
                sym_next = sym_inc;
                // Byte boundary: the byte's last symbol is being registered now,
                // so the next byte (or end of payload) is decided here.
                if (bound_sym) begin
                    have_next = packet;
                    if (packet) begin
                        nxt_next = data;
                        adv_next = 1'b1;
                        len_next = len_inc;
                    end
                end
                if (last_sym) begin
                    if (have_reg) begin
                        state_next = DATA;
                        byte_next  = nxt_reg;
                    end else if (pad_more) begin
                        state_next = PAD;
                        byte_next  = '0;
                        len_next   = len_inc;
                    end else begin
                        end_frame = 1'b1;
                    end
                end
            end
            PAD: begin
                sym_next = sym_inc;
                if (last_sym) begin
                    if (pad_more) len_next = len_inc;
                    else          end_frame = 1'b1;
                end
            end
`ifdef ETH_XMII_TX_FCS_EN
            FCS: begin
                sym_next = sym_inc;
                if (last_sym) begin
                    if (bcnt_reg == '0) begin
                        enter_ipg = 1'b1;
                    end else begin
                        bcnt_next = bcnt_reg - BW'(1);
                        byte_next = ~crc_reg[7:0];
                        crc_base  = {8'h00, crc_reg[31:8]};
                    end
                end
            end
`endif
            IPG: begin
                sym_next = sym_inc;
                // The IDLE cycle that follows is the last gap cycle, so the
                // quiet time on the wire is exactly IPG_BYTES*S cycles.
                if (bcnt_reg == '0 && bound_sym) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    sym_next   = '0;
                end else if (last_sym) begin
                    bcnt_next = bcnt_reg - BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (end_frame) begin
`ifdef ETH_XMII_TX_FCS_EN
            state_next = FCS;
            bcnt_next  = BW'(3);
            byte_next  = ~crc_reg[7:0];
            crc_base   = {8'h00, crc_reg[31:8]};
`else
            enter_ipg  = 1'b1;
`endif
        end
        if (enter_ipg) begin
            state_next = IPG;
            bcnt_next  = BW'(IPG_BYTES - 1);
            byte_next  = '0;
            txen_next  = 1'b0;
        end
    end

    for (genvar gi = 0; gi < S; gi++) begin : g_sym
        assign byte_sym[gi] = byte_next[gi*DW +: DW];
    end

    always_comb begin
        tx_next = byte_sym[sym_next];
    end

`ifdef ETH_XMII_TX_FCS_EN
    always_comb begin
        crc_next = crc_base;
        if (state_next == DATA || state_next == PAD) crc_next = crc_step(crc_base, tx_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_reg <= '1;
        else        crc_reg <= crc_next;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sym_reg   <= '0;
            bcnt_reg  <= '0;
            byte_reg  <= '0;
            nxt_reg   <= '0;
            have_reg  <= 1'b0;
            tx        <= '0;
            txen      <= 1'b0;
            advance   <= 1'b0;
            busy      <= 1'b0;
            len       <= '0;
        end else begin
            state_reg <= state_next;
            sym_reg   <= sym_next;
            bcnt_reg  <= bcnt_next;
            byte_reg  <= byte_next;
            nxt_reg   <= nxt_next;
            have_reg  <= have_next;
            tx        <= tx_next;
            txen      <= txen_next;
            advance   <= adv_next;
            busy      <= busy_next;
            len       <= len_next;
        end
    end
endmodule

// File: doc/eth_xmii_tx.md
Name: eth_xmii_tx

Overview:
- Parametrised Ethernet MAC transmit serializer; next generation of the team's RMII TX block.
- DW selects bus width: 2 = RMII, 4 = MII nibble.
- Generates preamble/SFD from parameters, pads short frames to a minimum length, and enforces a programmable inter-packet gap (IPG).
- Sits between the packet source (byte stream with a `packet` gate and `advance` handshake) and the PHY pins.

Parameters:
- DW, 2: symbol width in bits; legal values are 2 and 4; symbols per byte S = 8/DW.
- PRE_BYTES, 7: number of 0x55 preamble bytes sent before the 0xD5 SFD byte.
- MIN_BYTES, 60: minimum payload byte count; shorter frames are padded with 0x00.
- IPG_BYTES, 12: inter-packet gap length in byte times.

Ports:
- clk  in  1  PHY reference clock (50 MHz for RMII, 25 MHz for MII).
- rst_n  in  1  asynchronous, active-low reset.
- data  in  8  payload byte; sampled only at byte-boundary edges.
- packet  in  1  high = frame in progress and more data available.
- tx  out  DW  PHY transmit symbol.
- txen  out  1  PHY transmit enable.
- advance  out  1  one-cycle pulse; `data` was consumed on the previous edge.
- busy  out  1  high from frame start until IPG completes.
- len  out  11  payload bytes consumed in the current or last frame; saturates at 2047.

Behaviour:
- Reset: one clock, asynchronous, active-low (rst_n). While low, all outputs are 0 and state is IDLE. Assertion mid-frame drops txen immediately; no IPG runs.
- All outputs are registered.
- Bytes are sent LSB-first, DW bits per cycle, S cycles per byte.
- States: IDLE, PRE, SFD, DATA, PAD, FCS (present only with the optional feature), IPG.
- IDLE
  - txen = 0, tx = 0.
  - If packet is sampled high: next edge enters PRE, busy = 1, txen = 1, first preamble symbol on tx, len cleared to 0.
- PRE: drives PRE_BYTES*S symbols of pattern 0x55, then enters SFD.
- SFD: drives S symbols of 0xD5.
- Byte boundary: the edge on which the last symbol of the SFD or of a DATA byte is registered.
  - packet high: `data` is latched, DATA continues, advance pulses high the following cycle, len increments.
  - packet low: `data` is ignored and advance stays low.
    - len < MIN_BYTES: go to PAD.
    - otherwise: go to FCS (feature on) or IPG (feature off).
- Zero-length frame: packet deasserted before the SFD byte boundary. The frame is all padding (MIN_BYTES zero bytes).
- PAD: drives 0x00 bytes, incrementing len, until len == MIN_BYTES; no advance pulses.
- IPG
  - txen = 0, tx = 0 for IPG_BYTES*S cycles.
  - busy clears on the edge after the final IPG cycle; state returns to IDLE.
  - packet is ignored in IPG. If still high when IDLE is reached, the next frame starts on the following edge.
- Counters
  - Symbol counter is log2(S) bits and wraps at S-1.
  - Byte counter is wide enough for max(PRE_BYTES, IPG_BYTES, 4) and counts down to 0.
  - len saturates at 2047; it never wraps.
- Data changing off a byte boundary has no effect.
- Throughput: back-to-back bytes need `data` updated within S-1 cycles after each advance pulse.

Optional Feature:
- Macro: ETH_XMII_TX_FCS_EN.
- Defined
  - A CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement) is accumulated DW bits per cycle over all DATA and PAD bytes.
  - After DATA/PAD, the FCS state drives the 4 FCS bytes (4*S cycles, LSB-first, txen = 1), then enters IPG.
  - len excludes FCS bytes.
- Undefined
  - No CRC logic is built and the FCS state is absent.
  - The source must supply the FCS as payload; DATA/PAD go directly to IPG.

Test Plan:
- Preamble, DW=2: packet rises in IDLE -> txen high next cycle; 28 symbols of 2'b01, then 2'b01,2'b01,2'b01,2'b11 (SFD 0xD5); first advance pulse 1 cycle after the SFD boundary.
- Byte order, DW=4: 64-byte frame 0x00..0x3F -> nibbles 0,0,1,0,2,0,... on tx; exactly 64 advance pulses spaced 2 cycles apart; len = 64; txen low after the last nibble.
- Padding, DW=2: 10-byte frame -> 50 bytes of 0x00 after the payload; len = 60; no advance pulses during PAD.
- IPG/busy, DW=2, IPG_BYTES=12: packet held high across two frames -> txen low for exactly 48 cycles between frames; busy falls then rises again on consecutive edges.
- FCS, feature defined: 60-byte zero payload -> trailing 4 bytes equal the reference CRC-32 of the payload; frame is 60 bytes + FCS with no padding.
- Reset mid-DATA: rst_n pulled low for 1 ns -> tx, txen, busy, advance, len all 0 asynchronously; next packet starts from a clean preamble.
